// File: rtl/octave_folder_if.sv
// DFT-to-folder link: magnitude bins and start request in, folded note bins out.
// master = DFT/upstream side, slave = octave_folder.
interface octave_folder_if #(
    parameter int BPO = 24,
    parameter int OC  = 5,
    parameter int INW = 36
);
    localparam int OUTW = INW + $clog2(OC);

    logic [BPO*OC-1:0][INW-1:0] inBins;
    logic                       startFold;
    logic                       doingRead;
    logic [BPO-1:0][OUTW-1:0]   foldedBins;
    logic                       outValid;
    logic                       busy;

    modport master (
        output inBins, startFold,
        input  doingRead, foldedBins, outValid, busy
    );

    modport slave (
        input  inBins, startFold,
        output doingRead, foldedBins, outValid, busy
    );
endinterface

// File: rtl/octave_folder.sv
// Folds BPO*OC DFT bins into BPO per-note bins (octave sum) with IIR smoothing.
// startFold -> outValid after BPO*OC+1 cycles; startFold ignored while busy, never queued.
module octave_folder #(
    parameter int BPO       = 24,
    parameter int OC        = 5,
    parameter int INW       = 36,
    parameter int IIR_SHIFT = 2
) (
    input  logic          clk,
    input  logic          rst,
    octave_folder_if.slave bus
);
    localparam int OUTW = INW + $clog2(OC);
    localparam int BW   = (BPO > 1) ? $clog2(BPO) : 1;
    localparam int OW   = (OC > 1) ? $clog2(OC) : 1;
    localparam int IW   = $clog2(BPO*OC + 1);

    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    state_t                   state;
    logic [BW-1:0]            b;
    logic [OW-1:0]            o;
    logic [OUTW-1:0]          acc;
    logic [BPO-1:0][OUTW-1:0] folded;
    logic                     doing_read;
    logic                     out_valid;
    logic                     busy_r;

    logic [IW-1:0]            idx;
    logic [OUTW-1:0]          sum;
    logic [OUTW-1:0]          old;
    logic [OUTW-1:0]          nxt;

    // Note-major walk: all octaves of note b are visited back to back
    always_comb begin
        idx = IW'(o) * IW'(BPO) + IW'(b);
        sum = acc + OUTW'(bus.inBins[idx]);
        old = folded[b];
        nxt = old - (old >> IIR_SHIFT) + (sum >> IIR_SHIFT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            b          <= '0;
            o          <= '0;
            acc        <= '0;
            folded     <= '0;
            doing_read <= 1'b0;
            out_valid  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    if (bus.startFold) begin
                        state      <= READ;
                        doing_read <= 1'b1;
                        busy_r     <= 1'b1;
                        b          <= '0;
                        o          <= '0;
                        acc        <= '0;
                    end
                end
                READ: begin
                    if (o == OW'(OC - 1)) begin
                        folded[b] <= nxt;
                        acc       <= '0;
                        o         <= '0;
                        if (b == BW'(BPO - 1)) begin
                            b          <= '0;
                            state      <= DONE;
                            doing_read <= 1'b0;
                            out_valid  <= 1'b1;
                        end else begin
                            b <= b + 1'b1;
                        end
                    end else begin
                        acc <= sum;
                        o   <= o + 1'b1;
                    end
                end
                DONE: begin
                    out_valid <= 1'b0;
                    busy_r    <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.foldedBins = folded;
    assign bus.doingRead  = doing_read;
    assign bus.outValid   = out_valid;
    assign bus.busy       = busy_r;
endmodule

// File: tb/tb_octave_folder.sv
// Directed bench: dut0 runs unsmoothed (IIR_SHIFT=0), dut2 smoothed (IIR_SHIFT=2).
module tb_octave_folder;
    localparam int BPO = 24;
    localparam int OC  = 5;
    localparam int NB  = BPO * OC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    octave_folder_if #(.BPO(BPO), .OC(OC), .INW(36)) if0 ();
    octave_folder_if #(.BPO(BPO), .OC(OC), .INW(36)) if2 ();

    octave_folder #(.BPO(BPO), .OC(OC), .INW(36), .IIR_SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0)
    );
    octave_folder #(.BPO(BPO), .OC(OC), .INW(36), .IIR_SHIFT(2)) dut2 (
        .clk(clk), .rst(rst), .bus(if2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) if2.startFold = v;
        else     if0.startFold = v;
    endtask

    task automatic bins_const(input logic [35:0] v);
        for (int i = 0; i < NB; i++) begin
            if0.inBins[i] = v;
            if2.inBins[i] = v;
        end
    endtask

    task automatic check_folded(input bit sel, input string tag, input logic [63:0] exp_base,
                                input logic [63:0] exp_step);
        for (int bb = 0; bb < BPO; bb++) begin
            logic [63:0] got;
            got = sel ? 64'(if2.foldedBins[bb]) : 64'(if0.foldedBins[bb]);
            check($sformatf("%s[%0d]", tag, bb), got, exp_base + exp_step * 64'(bb));
        end
    endtask

    // One pass from IDLE: counts doingRead/outValid cycles, optional extra start pulses
    task automatic run_pass(input bit sel, input int pulse_at, input bit pulse_done,
                            output int dr_cnt, output int ov_cnt, output int dr_at_ov);
        bit finished;
        dr_cnt   = 0;
        ov_cnt   = 0;
        dr_at_ov = -1;
        finished = 0;
        set_start(sel, 1'b1);
        tick();
        set_start(sel, 1'b0);
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            logic dr, ov, bs;
            dr = sel ? if2.doingRead : if0.doingRead;
            ov = sel ? if2.outValid  : if0.outValid;
            bs = sel ? if2.busy      : if0.busy;
            if (!bs) begin
                finished = 1;
            end else begin
                if (dr) dr_cnt++;
                if (ov) begin
                    ov_cnt++;
                    dr_at_ov = dr_cnt;
                end
                set_start(sel, ((pulse_at >= 0) && dr && (dr_cnt == pulse_at)) || (pulse_done && ov));
                tick();
            end
        end
        set_start(sel, 1'b0);
        if (!finished) check("pass_timeout", 64'd1, 64'd0);
    endtask

    int dr_cnt, ov_cnt, dr_at_ov;

    initial begin
        if0.startFold = 1'b0;
        if2.startFold = 1'b0;
        bins_const(36'd0);

        // Reset and idle
        rst = 1'b1;
        repeat (500) tick();
        rst = 1'b0;
        repeat (5) tick();
        check("rst_doingRead", 64'(if0.doingRead), 64'd0);
        check("rst_outValid",  64'(if0.outValid),  64'd0);
        check("rst_busy",      64'(if0.busy),      64'd0);
        check("rst_busy2",     64'(if2.busy),      64'd0);
        check_folded(0, "rst_fold0", 64'd0, 64'd0);
        check_folded(1, "rst_fold2", 64'd0, 64'd0);

        // Unsmoothed constant input
        bins_const(36'd1000);
        run_pass(0, -1, 0, dr_cnt, ov_cnt, dr_at_ov);
        check("t2_doingRead_cycles", 64'(dr_cnt), 64'd120);
        check("t2_outValid_pulses",  64'(ov_cnt), 64'd1);
        check("t2_outValid_after",   64'(dr_at_ov), 64'd120);
        check_folded(0, "t2_fold", 64'd5000, 64'd0);

        // Smoothed: three passes from reset
        run_pass(1, -1, 0, dr_cnt, ov_cnt, dr_at_ov);
        check("t3_ov1", 64'(ov_cnt), 64'd1);
        check_folded(1, "t3_p1", 64'd1250, 64'd0);
        run_pass(1, -1, 0, dr_cnt, ov_cnt, dr_at_ov);
        check_folded(1, "t3_p2", 64'd2188, 64'd0);
        run_pass(1, -1, 0, dr_cnt, ov_cnt, dr_at_ov);
        check_folded(1, "t3_p3", 64'd2891, 64'd0);

        // Distinct per-octave/per-note pattern
        for (int o = 0; o < OC; o++)
            for (int bb = 0; bb < BPO; bb++)
                if0.inBins[o*BPO + bb] = 36'(o*100 + bb);
        run_pass(0, -1, 0, dr_cnt, ov_cnt, dr_at_ov);
        check_folded(0, "t4_fold", 64'd1000, 64'd5);

        // Start pulses during READ and DONE are dropped
        run_pass(0, 10, 1, dr_cnt, ov_cnt, dr_at_ov);
        check("t5_ov_in_pass", 64'(ov_cnt), 64'd1);
        check("t5_dr_cycles",  64'(dr_cnt), 64'd120);
        ov_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (if0.outValid || if0.busy) ov_cnt++;
            tick();
        end
        check("t5_no_extra_pass", 64'(ov_cnt), 64'd0);
        check("t5_busy_low", 64'(if0.busy), 64'd0);

        // Reset in the middle of READ
        if0.startFold = 1'b1;
        tick();
        if0.startFold = 1'b0;
        dr_cnt = 0;
        for (int i = 0; i < 400 && dr_cnt < 60; i++) begin
            if (if0.doingRead) dr_cnt++;
            if (dr_cnt < 60) tick();
        end
        check("t6_reached_cycle60", 64'(dr_cnt), 64'd60);
        rst = 1'b1;
        #1;
        check("t6_doingRead_drop", 64'(if0.doingRead), 64'd0);
        check("t6_busy_drop",      64'(if0.busy),      64'd0);
        check_folded(0, "t6_fold_cleared", 64'd0, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        bins_const(36'd1000);
        run_pass(0, -1, 0, dr_cnt, ov_cnt, dr_at_ov);
        check("t6_ov", 64'(ov_cnt), 64'd1);
        check_folded(0, "t6_fold", 64'd5000, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
